// File: rtl/obi_rule_demux.sv
// obi_rule_demux: address-rule decoded OBI 1-to-N demux with outstanding tracking,
// an internal error slave for unmapped addresses and sticky protocol-error flag.
module obi_rule_demux #(
   parameter int          NUM_RULES       = 6,
   parameter int          NUM_SLAVES      = 6,
   parameter int          MAX_OUTSTANDING = 4,
   parameter bit          DEFAULT_EN      = 1'b0,
   parameter int          DEFAULT_IDX     = 2,
   parameter logic [31:0] ERR_RDATA       = 32'hBADACCE5,
   localparam int         CW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_RULES*32-1:0] rule_start_i,
   input  logic [NUM_RULES*32-1:0] rule_end_i,
   input  logic [NUM_RULES*32-1:0] rule_idx_i,
   input  logic                    m_req_i,
   input  logic                    m_we_i,
   input  logic [3:0]              m_be_i,
   input  logic [31:0]             m_addr_i,
   input  logic [31:0]             m_wdata_i,
   output logic                    m_gnt_o,
   output logic                    m_rvalid_o,
   output logic                    m_err_o,
   output logic [31:0]             m_rdata_o,
   output logic [NUM_SLAVES-1:0]   s_req_o,
   output logic [NUM_SLAVES-1:0]   s_we_o,
   output logic [NUM_SLAVES*4-1:0] s_be_o,
   output logic [NUM_SLAVES*32-1:0] s_addr_o,
   output logic [NUM_SLAVES*32-1:0] s_wdata_o,
   input  logic [NUM_SLAVES-1:0]   s_gnt_i,
   input  logic [NUM_SLAVES-1:0]   s_rvalid_i,
   input  logic [NUM_SLAVES*32-1:0] s_rdata_i,
   output logic [CW-1:0]           outstanding_o,
   output logic                    proto_err_o
);
   // Target index NUM_SLAVES denotes the internal error slave.
   localparam int TW = $clog2(NUM_SLAVES + 1);
   logic [TW-1:0] tgt, held_q, held_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_pend_q, err_pend_d, proto_q, proto_d;
   logic          is_err, held_err, allow, gnt_sel, rv_sel, accept, bad_rv;
   logic [31:0]   rd_sel;
   assign s_we_o        = {NUM_SLAVES{m_we_i}};
   assign s_be_o        = {NUM_SLAVES{m_be_i}};
   assign s_addr_o      = {NUM_SLAVES{m_addr_i}};
   assign s_wdata_o     = {NUM_SLAVES{m_wdata_i}};
   assign outstanding_o = count_q;
   assign proto_err_o   = proto_q;
   always_comb begin
      tgt = DEFAULT_EN ? TW'(DEFAULT_IDX) : TW'(NUM_SLAVES);
      // Walk rules from highest to lowest so the lowest-numbered match wins.
      for (int i = NUM_RULES - 1; i >= 0; i--)
         if (rule_start_i[i*32 +: 32] < rule_end_i[i*32 +: 32] &&
             m_addr_i >= rule_start_i[i*32 +: 32] && m_addr_i < rule_end_i[i*32 +: 32] &&
             rule_idx_i[i*32 +: 32] < NUM_SLAVES)
            tgt = TW'(rule_idx_i[i*32 +: 32]);
      is_err   = tgt == TW'(NUM_SLAVES);
      held_err = held_q == TW'(NUM_SLAVES);
      allow    = !rst_i && count_q < CW'(MAX_OUTSTANDING) && (count_q == '0 || tgt == held_q);
      gnt_sel  = is_err;
      rv_sel   = 1'b0;
      rd_sel   = '0;
      bad_rv   = 1'b0;
      s_req_o  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         s_req_o[i] = m_req_i && allow && tgt == TW'(i);
         if (tgt == TW'(i)) gnt_sel = s_gnt_i[i];
         if (held_q == TW'(i)) begin
            rv_sel = s_rvalid_i[i];
            rd_sel = s_rdata_i[i*32 +: 32];
         end
         if (s_rvalid_i[i] && (count_q == '0 || held_q != TW'(i))) bad_rv = 1'b1;
      end
      m_gnt_o    = allow & gnt_sel;
      accept     = m_req_i & m_gnt_o;
      m_rvalid_o = !rst_i && count_q != '0 && (held_err ? err_pend_q : rv_sel);
      m_err_o    = m_rvalid_o & held_err;
      m_rdata_o  = held_err ? ERR_RDATA : rd_sel;
      held_d     = accept ? tgt : held_q;
      err_pend_d = accept & is_err;
      count_d    = count_q + CW'(accept) - CW'(m_rvalid_o);
      proto_d    = proto_q | bad_rv;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q    <= '0;
         held_q     <= '0;
         err_pend_q <= 1'b0;
         proto_q    <= 1'b0;
      end else begin
         count_q    <= count_d;
         held_q     <= held_d;
         err_pend_q <= err_pend_d;
         proto_q    <= proto_d;
      end
   end
endmodule
